// File: rtl/player_cmd_gen.sv
// Player command generator: debounced buttons to frame-aligned move/jump commands with hit stun.
// Optional jump buffering is enabled by defining JUMP_BUFFER_EN.
module player_cmd_gen #(
  parameter int unsigned DEB_CYCLES      = 250000,
  parameter int unsigned STUN_FRAMES     = 12,
  parameter int unsigned JUMP_BUF_FRAMES = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic SCEN,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_jump,
  input  logic jump_active,
  input  logic hit,
  output logic move_left,
  output logic move_right,
  output logic jump,
  output logic move_enable
);

  localparam int unsigned DebW  = $clog2(DEB_CYCLES) + 1;
  localparam int unsigned StunW = $clog2(STUN_FRAMES) + 1;

  localparam logic [DebW-1:0]  DebLast  = DebW'(DEB_CYCLES - 1);
  localparam logic [StunW-1:0] StunLoad = StunW'(STUN_FRAMES);

  if (DEB_CYCLES == 0 || STUN_FRAMES == 0 || JUMP_BUF_FRAMES == 0) begin : g_bad_param
    $error("player_cmd_gen: DEB_CYCLES, STUN_FRAMES and JUMP_BUF_FRAMES must be nonzero");
  end

  typedef enum logic [1:0] {J_IDLE, J_PEND, J_ISSUE, J_RELEASE} jump_state_e;

  // Bit order for the per-button vectors: 0 left, 1 right, 2 jump.
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] db;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_jump, btn_right, btn_left};
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [DebW-1:0] cnt;
    logic            lvl;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == DebLast) begin
        cnt <= '0;
        lvl <= sync2[i];
      end else begin
        cnt <= cnt + DebW'(1);
      end
    end

    assign db[i] = lvl;
  end

  // After reset the jump edge detector stays disarmed until the jump button has been
  // seen released for a full debounce period, so a button held through reset cannot fire.
  logic [1:0]      sync_fill;
  logic            jump_armed;
  logic [DebW-1:0] rel_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_fill  <= '0;
      jump_armed <= 1'b0;
      rel_cnt    <= '0;
    end else begin
      sync_fill <= {sync_fill[0], 1'b1};
      if (!jump_armed) begin
        if (sync_fill[1] && !sync2[2]) begin
          if (rel_cnt == DebLast) begin
            jump_armed <= 1'b1;
          end else begin
            rel_cnt <= rel_cnt + DebW'(1);
          end
        end else begin
          rel_cnt <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_left  <= 1'b0;
      move_right <= 1'b0;
    end else if (SCEN) begin
      move_left  <= db[0] & ~db[1];
      move_right <= db[1] & ~db[0];
    end
  end

  // stun_pend marks a hit not yet reflected in move_enable; that SCEN does not count down.
  logic [StunW-1:0] stun_cnt;
  logic             stun_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stun_cnt    <= '0;
      stun_pend   <= 1'b0;
      move_enable <= 1'b1;
    end else begin
      if (SCEN && stun_pend) begin
        move_enable <= 1'b0;
      end
      stun_pend <= hit | (stun_pend & ~SCEN);
      if (hit) begin
        stun_cnt <= StunLoad;
      end else if (SCEN && !stun_pend && stun_cnt != '0) begin
        stun_cnt <= stun_cnt - StunW'(1);
        if (stun_cnt == StunW'(1)) begin
          move_enable <= 1'b1;
        end
      end
    end
  end

  jump_state_e jstate;
  logic        db_j_prev;
  logic        jump_rise;
  logic        jump_ok;

  assign jump_rise = jump_armed & db[2] & ~db_j_prev;
  assign jump_ok   = ~jump_active & move_enable;

`ifdef JUMP_BUFFER_EN
  localparam int unsigned BufW = $clog2(JUMP_BUF_FRAMES) + 1;
  localparam logic [BufW-1:0] BufLoad = BufW'(JUMP_BUF_FRAMES);
  logic [BufW-1:0] buf_cnt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jstate    <= J_IDLE;
      jump      <= 1'b0;
      db_j_prev <= 1'b0;
`ifdef JUMP_BUFFER_EN
      buf_cnt   <= '0;
`endif
    end else begin
      db_j_prev <= db[2];
      case (jstate)
        J_IDLE: begin
          if (jump_rise) begin
            jstate <= J_PEND;
`ifdef JUMP_BUFFER_EN
            buf_cnt <= BufLoad;
`endif
          end
        end
        J_PEND: begin
          if (SCEN) begin
            if (jump_ok) begin
              jump   <= 1'b1;
              jstate <= J_ISSUE;
            end else begin
`ifdef JUMP_BUFFER_EN
              // Each ineligible frame spends one buffer credit; out of credit drops the press.
              if (buf_cnt != '0) begin
                buf_cnt <= buf_cnt - BufW'(1);
              end else begin
                jstate <= db[2] ? J_RELEASE : J_IDLE;
              end
`else
              jstate <= db[2] ? J_RELEASE : J_IDLE;
`endif
            end
          end
        end
        J_ISSUE: begin
          if (SCEN) begin
            jump   <= 1'b0;
            jstate <= db[2] ? J_RELEASE : J_IDLE;
          end
        end
        J_RELEASE: begin
          if (!db[2]) begin
            jstate <= J_IDLE;
          end
        end
        default: jstate <= J_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_cmd_gen.sv
// Scoreboard bench for player_cmd_gen: stimulus queues per-frame expectations, a monitor
// compares outputs after every SCEN edge. Honours JUMP_BUFFER_EN for the buffered-jump case.
module tb_player_cmd_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic SCEN = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic btn_jump = 1'b0;
  logic jump_active = 1'b0;
  logic hit = 1'b0;
  logic move_left, move_right, jump, move_enable;

  int cyc = 0;
  int base = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    logic [3:0] v;  // {move_left, move_right, jump, move_enable}
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  player_cmd_gen #(
    .DEB_CYCLES     (4),
    .STUN_FRAMES    (3),
    .JUMP_BUF_FRAMES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .SCEN       (SCEN),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .jump_active(jump_active),
    .hit        (hit),
    .move_left  (move_left),
    .move_right (move_right),
    .jump       (jump),
    .move_enable(move_enable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SCEN is high for every posedge whose index is a multiple of 10.
  initial forever begin
    @(negedge clk);
    SCEN = ((cyc + 1) % 10 == 0);
  end

  task automatic check(input string name, input logic act, input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0b want %0b (t=%0t)", name, act, want, $time);
    end
  endtask

  always @(posedge clk) begin
    if (SCEN) begin
      #1;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check({mon_e.tag, " move_left"}, move_left, mon_e.v[3]);
        check({mon_e.tag, " move_right"}, move_right, mon_e.v[2]);
        check({mon_e.tag, " jump"}, jump, mon_e.v[1]);
        check({mon_e.tag, " move_enable"}, move_enable, mon_e.v[0]);
      end
    end
  end

  task automatic push(input string tag, input logic [3:0] v);
    exp_t x;
    x.tag = tag;
    x.v   = v;
    exp_q.push_back(x);
  endtask

  // Drive so that the change is sampled at posedge base+t.
  task automatic at(input int t);
    while (cyc < base + t - 1) @(negedge clk);
  endtask

  task automatic align();
    while (cyc % 10 != 0) @(negedge clk);
    base = cyc;
  endtask

  task automatic finish_frames(input string name, input int f);
    at(10 * f + 2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s leftover: got %0d unchecked frames want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_jump = 1'b0;
    jump_active = 1'b0;
    hit = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    align();
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check("reset move_left", move_left, 1'b0);
    check("reset move_right", move_right, 1'b0);
    check("reset jump", jump, 1'b0);
    check("reset move_enable", move_enable, 1'b1);

    // A: short right glitch ignored; left, then left+right cancel, then right only.
    do_reset();
    push("A1", 4'b0001); push("A2", 4'b1001); push("A3", 4'b0001);
    push("A4", 4'b0101); push("A5", 4'b0001);
    at(2);  btn_right = 1'b1;
    at(5);  btn_right = 1'b0;
    at(12); btn_left = 1'b1;
    at(22); btn_right = 1'b1;
    at(32); btn_left = 1'b0;
    at(42); btn_right = 1'b0;
    finish_frames("A", 5);

    // B: held jump fires once; re-press after release fires again.
    do_reset();
    push("B1", 4'b0011); push("B2", 4'b0001); push("B3", 4'b0001); push("B4", 4'b0001);
    push("B5", 4'b0001); push("B6", 4'b0001); push("B7", 4'b0011); push("B8", 4'b0001);
    at(2);  btn_jump = 1'b1;
    at(52); btn_jump = 1'b0;
    at(62); btn_jump = 1'b1;
    at(72); btn_jump = 1'b0;
    finish_frames("B", 8);

    // C: stun, reload while stunned, left tracked and jump blocked during stun,
    // then a hit coinciding with SCEN.
    do_reset();
    push("C1", 4'b0001); push("C2", 4'b0000); push("C3", 4'b1000); push("C4", 4'b1000);
    push("C5", 4'b1000); push("C6", 4'b1000); push("C7", 4'b1001); push("C8", 4'b1001);
    push("C9", 4'b1001); push("C10", 4'b1000); push("C11", 4'b1000); push("C12", 4'b1000);
    push("C13", 4'b1001);
    at(15); hit = 1'b1;
    at(16); hit = 1'b0;
    at(22); btn_left = 1'b1;
    at(35); hit = 1'b1;
    at(36); hit = 1'b0;
    at(42); btn_jump = 1'b1;
    at(52); btn_jump = 1'b0;
    at(90); hit = 1'b1;
    at(91); hit = 1'b0;
    finish_frames("C", 13);
    btn_left = 1'b0;

    // E: press while airborne for one frame.
    do_reset();
    push("E1", 4'b0001);
`ifdef JUMP_BUFFER_EN
    push("E2", 4'b0011);
`else
    push("E2", 4'b0001);
`endif
    push("E3", 4'b0001); push("E4", 4'b0001);
    at(1);  jump_active = 1'b1;
    at(2);  btn_jump = 1'b1;
    at(11); jump_active = 1'b0;
    at(32); btn_jump = 1'b0;
    finish_frames("E", 4);

    // F: reset during jump pulse and stun; held jump must not fire afterwards.
    do_reset();
    push("F1", 4'b1010);
    at(2); btn_left = 1'b1; btn_jump = 1'b1;
    at(5); hit = 1'b1;
    at(6); hit = 1'b0;
    finish_frames("F", 1);
    reset = 1'b1;
    btn_left = 1'b0;
    #1;
    check("F reset move_left", move_left, 1'b0);
    check("F reset move_right", move_right, 1'b0);
    check("F reset jump", jump, 1'b0);
    check("F reset move_enable", move_enable, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    align();
    push("G1", 4'b0001); push("G2", 4'b0001); push("G3", 4'b0001);
    push("G4", 4'b0011); push("G5", 4'b0001);
    at(22); btn_jump = 1'b0;
    at(32); btn_jump = 1'b1;
    at(42); btn_jump = 1'b0;
    finish_frames("G", 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
